// File: rtl/mul_red_pipe.sv
// Elastic dual-mode (Kyber 2x12b / Dilithium 1x23b) modular multiplier.
// Three stages: product, Barrett fold to [0,2q), conditional subtract.
module mul_red_pipe #(
    parameter int LANES = 2,
    parameter int TAG_W = 8,
    parameter int KQ    = 3329,
    parameter int DQ    = 8380417
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_mode,
    input  logic [24*LANES-1:0]   in_a,
    input  logic [24*LANES-1:0]   in_w,
    input  logic [TAG_W-1:0]      in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_mode,
    output logic [24*LANES-1:0]   out_data,
    output logic [TAG_W-1:0]      out_tag,
    output logic                  busy
);

    localparam int PW = 48;
    localparam int RW = 26;
    localparam logic [12:0] KQV = 13'(KQ);
    localparam logic [23:0] DQV = 24'(DQ);
    localparam logic [12:0] KM  = 13'((64'd1 << 24) / 64'(KQ));
    localparam logic [23:0] DM  = 24'((64'd1 << 46) / 64'(DQ));

    function automatic logic [PW-1:0] mul_lane(input logic m,
                                               input logic [23:0] a,
                                               input logic [23:0] w);
        logic [PW-1:0] p;
        if (m) begin
            p = {2'b00, 46'(a[22:0]) * 46'(w[22:0])};
        end else begin
            p = {24'(a[23:12]) * 24'(w[23:12]),
                 24'(a[11:0]) * 24'(w[11:0])};
        end
        return p;
    endfunction

    function automatic logic [12:0] kfold(input logic [23:0] x);
        logic [36:0] t;
        logic [12:0] qe;
        logic [24:0] s;
        t  = 37'(x) * 37'(KM);
        qe = 13'(t >> 24);
        s  = 25'(x) - 25'(qe) * 25'(KQV);
        return 13'(s);
    endfunction

    function automatic logic [23:0] dfold(input logic [45:0] x);
        logic [69:0] t;
        logic [23:0] qe;
        logic [46:0] s;
        t  = 70'(x) * 70'(DM);
        qe = 24'(t >> 46);
        s  = 47'(x) - 47'(qe) * 47'(DQV);
        return 24'(s);
    endfunction

    function automatic logic [RW-1:0] fold_lane(input logic m,
                                                input logic [PW-1:0] p);
        logic [RW-1:0] r;
        if (m) r = {2'b00, dfold(p[45:0])};
        else   r = {kfold(p[47:24]), kfold(p[23:0])};
        return r;
    endfunction

    function automatic logic [11:0] kfin(input logic [12:0] r);
        logic [12:0] t;
        t = (r >= KQV) ? r - KQV : r;
        return 12'(t);
    endfunction

    function automatic logic [22:0] dfin(input logic [23:0] r);
        logic [23:0] t;
        t = (r >= DQV) ? r - DQV : r;
        return 23'(t);
    endfunction

    function automatic logic [23:0] fin_lane(input logic m,
                                             input logic [RW-1:0] r);
        logic [23:0] o;
        if (m) o = {1'b0, dfin(r[23:0])};
        else   o = {kfin(r[25:13]), kfin(r[12:0])};
        return o;
    endfunction

    logic                  alive_q, alive_d;
    logic                  s1_v_q, s1_v_d, s1_mode_q, s1_mode_d;
    logic [TAG_W-1:0]      s1_tag_q, s1_tag_d;
    logic [LANES*PW-1:0]   s1_p_q, s1_p_d;
    logic                  s2_v_q, s2_v_d, s2_mode_q, s2_mode_d;
    logic [TAG_W-1:0]      s2_tag_q, s2_tag_d;
    logic [LANES*RW-1:0]   s2_r_q, s2_r_d;
    logic                  s3_v_q, s3_v_d, out_mode_q, out_mode_d;
    logic [TAG_W-1:0]      out_tag_q, out_tag_d;
    logic [24*LANES-1:0]   out_data_q, out_data_d;
    logic                  s1_ld, s2_ld, s3_ld, in_fire;

    // Handshake, stage advance and per-stage datapath next state
    always_comb begin
        s3_ld    = out_ready | ~s3_v_q;
        s2_ld    = ~s2_v_q | s3_ld;
        s1_ld    = ~s1_v_q | s2_ld;
        in_ready = s1_ld & ~flush & alive_q;
        in_fire  = in_valid & in_ready;
        alive_d  = 1'b1;

        s1_v_d     = s1_v_q;
        s1_mode_d  = s1_mode_q;
        s1_tag_d   = s1_tag_q;
        s1_p_d     = s1_p_q;
        s2_v_d     = s2_v_q;
        s2_mode_d  = s2_mode_q;
        s2_tag_d   = s2_tag_q;
        s2_r_d     = s2_r_q;
        s3_v_d     = s3_v_q;
        out_mode_d = out_mode_q;
        out_tag_d  = out_tag_q;
        out_data_d = out_data_q;

        if (s1_ld) s1_v_d = in_fire;
        if (in_fire) begin
            s1_mode_d = in_mode;
            s1_tag_d  = in_tag;
            for (int i = 0; i < LANES; i++) begin
                s1_p_d[PW*i +: PW] = mul_lane(in_mode,
                    in_a[24*i +: 24], in_w[24*i +: 24]);
            end
        end

        if (s2_ld) s2_v_d = s1_v_q;
        if (s2_ld && s1_v_q) begin
            s2_mode_d = s1_mode_q;
            s2_tag_d  = s1_tag_q;
            for (int i = 0; i < LANES; i++) begin
                s2_r_d[RW*i +: RW] = fold_lane(s1_mode_q,
                    s1_p_q[PW*i +: PW]);
            end
        end

        if (s3_ld) s3_v_d = s2_v_q;
        if (s3_ld && s2_v_q) begin
            out_mode_d = s2_mode_q;
            out_tag_d  = s2_tag_q;
            for (int i = 0; i < LANES; i++) begin
                out_data_d[24*i +: 24] = fin_lane(s2_mode_q,
                    s2_r_q[RW*i +: RW]);
            end
        end

        if (flush) begin
            s1_v_d = 1'b0;
            s2_v_d = 1'b0;
            s3_v_d = 1'b0;
        end
    end

    // Pipeline state; reset empties the pipe and zeroes the outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alive_q    <= 1'b0;
            s1_v_q     <= 1'b0;
            s1_mode_q  <= 1'b0;
            s1_tag_q   <= '0;
            s1_p_q     <= '0;
            s2_v_q     <= 1'b0;
            s2_mode_q  <= 1'b0;
            s2_tag_q   <= '0;
            s2_r_q     <= '0;
            s3_v_q     <= 1'b0;
            out_mode_q <= 1'b0;
            out_tag_q  <= '0;
            out_data_q <= '0;
        end else begin
            alive_q    <= alive_d;
            s1_v_q     <= s1_v_d;
            s1_mode_q  <= s1_mode_d;
            s1_tag_q   <= s1_tag_d;
            s1_p_q     <= s1_p_d;
            s2_v_q     <= s2_v_d;
            s2_mode_q  <= s2_mode_d;
            s2_tag_q   <= s2_tag_d;
            s2_r_q     <= s2_r_d;
            s3_v_q     <= s3_v_d;
            out_mode_q <= out_mode_d;
            out_tag_q  <= out_tag_d;
            out_data_q <= out_data_d;
        end
    end

    assign out_valid = s3_v_q;
    assign out_mode  = out_mode_q;
    assign out_tag   = out_tag_q;
    assign out_data  = out_data_q;
    assign busy      = s1_v_q | s2_v_q | s3_v_q;

endmodule

// File: tb/tb_mul_red_pipe.sv
// Directed bench for mul_red_pipe: arithmetic, latency, backpressure,
// flush and asynchronous reset.
module tb_mul_red_pipe;

    logic        clk, rst, flush;
    logic        in_valid, in_ready, in_mode;
    logic [47:0] in_a, in_w;
    logic [7:0]  in_tag;
    logic        out_valid, out_ready, out_mode, busy;
    logic [47:0] out_data;
    logic [7:0]  out_tag;

    int checks   = 0;
    int failures = 0;

    mul_red_pipe #(.LANES(2), .TAG_W(8), .KQ(3329), .DQ(8380417)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .in_a(in_a), .in_w(in_w), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_mode(out_mode), .out_data(out_data), .out_tag(out_tag),
        .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [23:0] ref_lane(input logic m,
                                             input logic [23:0] a,
                                             input logic [23:0] w);
        logic [63:0] p;
        logic [31:0] h, l;
        if (m) begin
            p = (64'(a[22:0]) * 64'(w[22:0])) % 64'd8380417;
            return 24'(p);
        end
        h = (32'(a[23:12]) * 32'(w[23:12])) % 32'd3329;
        l = (32'(a[11:0]) * 32'(w[11:0])) % 32'd3329;
        return {12'(h), 12'(l)};
    endfunction

    function automatic logic [47:0] ref_beat(input logic m,
                                             input logic [47:0] a,
                                             input logic [47:0] w);
        return {ref_lane(m, a[47:24], w[47:24]),
                ref_lane(m, a[23:0], w[23:0])};
    endfunction

    function automatic logic [47:0] bp_a(input int i);
        return {24'(32'hABCDEF * 32'(i + 3)),
                24'(32'h123457 * 32'(i + 1))};
    endfunction

    function automatic logic [47:0] bp_w(input int i);
        return {24'(32'h7654321 ^ (32'(i) * 32'h1F1F1)),
                24'(32'hFFFFFF - 32'(i) * 32'h10101)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic m, input logic [47:0] a,
                         input logic [47:0] w, input logic [7:0] t);
        in_valid = 1'b1;
        in_mode  = m;
        in_a     = a;
        in_w     = w;
        in_tag   = t;
    endtask

    task automatic expect_beat(input string tag, input logic m,
                               input logic [47:0] d, input logic [7:0] t);
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_data"}, 64'(out_data), 64'(d));
        chk({tag, "_mode"}, 64'(out_mode), 64'(m));
        chk({tag, "_tag"}, 64'(out_tag), 64'(t));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_out_data"}, 64'(out_data), 64'd0);
        chk({tag, "_out_mode"}, 64'(out_mode), 64'd0);
        chk({tag, "_out_tag"}, 64'(out_tag), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    endtask

    initial begin
        int sent, recv, fullseen;
        logic fire_in, fire_out;

        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_mode = 1'b0;
        in_a = '0; in_w = '0; in_tag = '0; out_ready = 1'b1;

        // reset state
        tick();
        check_reset_outputs("rst0");
        #3 rst = 1'b1;
        tick();
        chk("rst0_release_ready", 64'(in_ready), 64'd1);
        chk("rst0_release_busy", 64'(busy), 64'd0);

        // Kyber edge values plus unreduced operands, latency
        drive(1'b0, {24'hFFFFFF, 24'hD00002}, {24'hFFFFFF, 24'hD00681}, 8'h11);
        chk("t1_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        chk("t1_lat0", 64'(out_valid), 64'd0);
        tick();
        chk("t1_lat1", 64'(out_valid), 64'd0);
        tick();
        expect_beat("t1", 1'b0, {24'h354354, 24'h001001}, 8'h11);
        tick();
        chk("t1_after", 64'(out_valid), 64'd0);

        // alternating modes back-to-back
        drive(1'b1, {24'd4194304, 24'd8380416}, {24'd2, 24'd8380416}, 8'h21);
        tick();
        drive(1'b0, {24'h0640C8, 24'h001002}, {24'h032028, 24'h005003}, 8'h22);
        tick();
        drive(1'b1, {24'h000000, 24'hFFFFFF}, {24'h000005, 24'h000002}, 8'h23);
        tick();
        in_valid = 1'b0;
        expect_beat("t3_d1", 1'b1, {24'h001FFF, 24'h000001}, 8'h21);
        tick();
        expect_beat("t3_k", 1'b0, {24'h68753E, 24'h005006}, 8'h22);
        tick();
        expect_beat("t3_d2", 1'b1, {24'h000000, 24'h003FFC}, 8'h23);
        tick();
        chk("t3_after", 64'(out_valid), 64'd0);

        // backpressure: 8 beats, out_ready low for 5 cycles
        sent = 0; recv = 0; fullseen = 0;
        for (int cyc = 0; cyc < 60 && recv < 8; cyc++) begin
            out_ready = !(cyc >= 4 && cyc < 9);
            if (sent < 8)
                drive(sent[0], bp_a(sent), bp_w(sent), 8'(sent));
            else
                in_valid = 1'b0;
            #1;
            if (out_valid) begin
                chk("t4_tag", 64'(out_tag), 64'(recv));
                chk("t4_mode", 64'(out_mode), 64'(recv[0]));
                chk("t4_data", 64'(out_data),
                    64'(ref_beat(recv[0], bp_a(recv), bp_w(recv))));
            end
            if (!out_ready && (sent - recv) == 3) begin
                fullseen++;
                chk("t4_full_ready", 64'(in_ready), 64'd0);
            end
            fire_in  = in_valid && in_ready;
            fire_out = out_valid && out_ready;
            tick();
            if (fire_in) sent++;
            if (fire_out) recv++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("t4_recv", 64'(recv), 64'd8);
        chk("t4_sent", 64'(sent), 64'd8);
        chk("t4_fullseen", 64'(fullseen > 0), 64'd1);

        // flush with a full pipe and a beat offered
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, bp_a(k), bp_w(k), 8'(8'h50 + k));
            tick();
        end
        chk("t5_full_busy", 64'(busy), 64'd1);
        chk("t5_full_ready", 64'(in_ready), 64'd0);
        flush = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, bp_a(9), bp_w(9), 8'h5F);
        #1;
        chk("t5_flush_ready", 64'(in_ready), 64'd0);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_out_valid", 64'(out_valid), 64'd0);
        drive(1'b0, {24'h000000, 24'h001002}, {24'h000007, 24'h005003}, 8'h60);
        tick();
        in_valid = 1'b0;
        chk("t5_lat0", 64'(out_valid), 64'd0);
        tick();
        chk("t5_lat1", 64'(out_valid), 64'd0);
        tick();
        expect_beat("t5_y", 1'b0, {24'h000000, 24'h005006}, 8'h60);
        tick();
        chk("t5_after", 64'(out_valid), 64'd0);

        // asynchronous reset with a full pipe
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, bp_a(k), bp_w(k), 8'(8'h70 + k));
            tick();
        end
        in_valid = 1'b0;
        chk("t6_full_valid", 64'(out_valid), 64'd1);
        #2 rst = 1'b0;
        #1;
        check_reset_outputs("t6_rst");
        @(posedge clk);
        #3 rst = 1'b1;
        out_ready = 1'b1;
        tick();
        chk("t6_ready", 64'(in_ready), 64'd1);
        chk("t6_no_stale", 64'(out_valid), 64'd0);
        drive(1'b1, {24'd4194304, 24'd8380416}, {24'd2, 24'd8380416}, 8'h80);
        tick();
        in_valid = 1'b0;
        chk("t6_lat0", 64'(out_valid), 64'd0);
        tick();
        chk("t6_lat1", 64'(out_valid), 64'd0);
        tick();
        expect_beat("t6_z", 1'b1, {24'h001FFF, 24'h000001}, 8'h80);
        tick();
        chk("t6_after", 64'(out_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
